// File: rtl/multi_filter_mac_engine_pkg.sv
// multi_filter_mac_engine_pkg: shared width derivations and beat flag struct for the MAC engine family
package multi_filter_mac_engine_pkg;

    function automatic int acc_width(input int if_w, input int filt_w, input int guard);
        return if_w + filt_w + guard;
    endfunction

    function automatic int sel_len(input int n);
        return $clog2(n);
    endfunction

    // control flags that travel with every operand beat
    typedef struct packed {
        logic first;
        logic last;
        logic use_ext_psum;
    } beat_flags_t;

endpackage

// File: rtl/multi_filter_mac_engine_psum_bank.sv
// psum_bank: banked partial-sum register file, async read, sync write/clear, async active-low reset
module psum_bank #(
    parameter int NUM_FILT   = 4,
    parameter int PSUM_DEPTH = 4,
    parameter int WIDTH      = 20,
    localparam int DEPTH     = NUM_FILT * PSUM_DEPTH,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];

    assign rdata = mem_q[raddr];

    // next-state of the bank: clear wins over a write
    always_comb begin
        mem_d = mem_q;
        if (clr) begin
            for (int i = 0; i < DEPTH; i++) mem_d[i] = '0;
        end else if (we) begin
            mem_d[waddr] = wdata;
        end
    end

    // storage with asynchronous clear of every entry
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            mem_q <= mem_d;
        end
    end

endmodule

// File: rtl/multi_filter_mac_engine.sv
// multi_filter_mac_engine: 3-stage MAC pipeline into a banked psum scratchpad with a valid/ready result port
module multi_filter_mac_engine import multi_filter_mac_engine_pkg::*; #(
    parameter int  IF_WIDTH   = 8,
    parameter int  FILT_WIDTH = 8,
    parameter int  ACC_GUARD  = 4,
    parameter int  NUM_FILT   = 4,
    parameter int  PSUM_DEPTH = 4,
    parameter bit  SATURATE   = 1'b0,
    localparam int ACC_WIDTH  = acc_width(IF_WIDTH, FILT_WIDTH, ACC_GUARD),
    localparam int FSEL_LEN   = sel_len(NUM_FILT),
    localparam int PADDR_LEN  = sel_len(PSUM_DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [IF_WIDTH-1:0]   if_data,
    input  logic [FILT_WIDTH-1:0] filt_data,
    input  logic [FSEL_LEN-1:0]   filt_sel,
    input  logic [PADDR_LEN-1:0]  psum_addr,
    input  logic                  first,
    input  logic                  last,
    input  logic                  use_ext_psum,
    input  logic [ACC_WIDTH-1:0]  ext_psum,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ACC_WIDTH-1:0]  out_data,
    output logic [FSEL_LEN-1:0]   out_filt_sel,
    output logic [PADDR_LEN-1:0]  out_psum_addr,
    output logic                  overflow,
    output logic                  busy
);

    localparam int PROD_WIDTH = IF_WIDTH + FILT_WIDTH;

    typedef struct packed {
        logic [FSEL_LEN-1:0]  filt_sel;
        logic [PADDR_LEN-1:0] psum_addr;
        beat_flags_t          flags;
    } beat_tag_t;

    logic                  advance, wr_en, load_out, carry;
    beat_tag_t             in_tag;
    logic [ACC_WIDTH-1:0]  base, res, wr_data, rd_data;
    logic [ACC_WIDTH:0]    sum;
    logic                  s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d, s3_valid_q, s3_valid_d;
    logic [IF_WIDTH-1:0]   s1_if_q, s1_if_d;
    logic [FILT_WIDTH-1:0] s1_filt_q, s1_filt_d;
    beat_tag_t             s1_tag_q, s1_tag_d, s2_tag_q, s2_tag_d, s3_tag_q, s3_tag_d;
    logic [ACC_WIDTH-1:0]  s1_ext_q, s1_ext_d, s2_ext_q, s2_ext_d, s3_ext_q, s3_ext_d;
    logic [ACC_WIDTH-1:0]  s2_prod_q, s2_prod_d, s3_prod_q, s3_prod_d;
    logic                  out_valid_q, out_valid_d, ovf_q, ovf_d;
    logic [ACC_WIDTH-1:0]  out_data_q, out_data_d;
    logic [FSEL_LEN-1:0]   out_fsel_q, out_fsel_d;
    logic [PADDR_LEN-1:0]  out_paddr_q, out_paddr_d;

    // the whole pipe stalls while a result waits downstream, even if S3 holds no last beat
    always_comb begin
        advance = !(out_valid_q && !out_ready) && !clr;
        in_tag.filt_sel = filt_sel;
        in_tag.psum_addr = psum_addr;
        in_tag.flags.first = first;
        in_tag.flags.last = last;
        in_tag.flags.use_ext_psum = use_ext_psum && first;
        s1_valid_d = clr ? 1'b0 : (advance ? in_valid : s1_valid_q);
        s2_valid_d = clr ? 1'b0 : (advance ? s1_valid_q : s2_valid_q);
        s3_valid_d = clr ? 1'b0 : (advance ? s2_valid_q : s3_valid_q);
        s1_if_d = advance ? if_data : s1_if_q;
        s1_filt_d = advance ? filt_data : s1_filt_q;
        s1_tag_d = advance ? in_tag : s1_tag_q;
        s1_ext_d = advance ? ext_psum : s1_ext_q;
        s2_prod_d = advance ? ACC_WIDTH'(PROD_WIDTH'(s1_if_q) * PROD_WIDTH'(s1_filt_q)) : s2_prod_q;
        s2_tag_d = advance ? s1_tag_q : s2_tag_q;
        s2_ext_d = advance ? s1_ext_q : s2_ext_q;
        s3_prod_d = advance ? s2_prod_q : s3_prod_q;
        s3_tag_d = advance ? s2_tag_q : s3_tag_q;
        s3_ext_d = advance ? s2_ext_q : s3_ext_q;
    end

    // S3 accumulate: read-modify-write of the entry; a last beat leaves the entry zeroed
    always_comb begin
        base = s3_tag_q.flags.first ? (s3_tag_q.flags.use_ext_psum ? s3_ext_q : '0) : rd_data;
        sum = {1'b0, base} + {1'b0, s3_prod_q};
        carry = sum[ACC_WIDTH];
        res = (carry && SATURATE) ? '1 : sum[ACC_WIDTH-1:0];
        wr_en = advance && s3_valid_q;
        wr_data = s3_tag_q.flags.last ? '0 : res;
        load_out = wr_en && s3_tag_q.flags.last;
        out_valid_d = clr ? 1'b0 : (load_out ? 1'b1 : (out_ready ? 1'b0 : out_valid_q));
        out_data_d = load_out ? res : out_data_q;
        out_fsel_d = load_out ? s3_tag_q.filt_sel : out_fsel_q;
        out_paddr_d = load_out ? s3_tag_q.psum_addr : out_paddr_q;
        ovf_d = clr ? 1'b0 : (ovf_q || (wr_en && carry));
    end

    // pipeline, output register and sticky overflow state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid_q <= 1'b0;
            s2_valid_q <= 1'b0;
            s3_valid_q <= 1'b0;
            s1_if_q <= '0;
            s1_filt_q <= '0;
            s1_tag_q <= '0;
            s1_ext_q <= '0;
            s2_prod_q <= '0;
            s2_tag_q <= '0;
            s2_ext_q <= '0;
            s3_prod_q <= '0;
            s3_tag_q <= '0;
            s3_ext_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q <= '0;
            out_fsel_q <= '0;
            out_paddr_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s2_valid_q <= s2_valid_d;
            s3_valid_q <= s3_valid_d;
            s1_if_q <= s1_if_d;
            s1_filt_q <= s1_filt_d;
            s1_tag_q <= s1_tag_d;
            s1_ext_q <= s1_ext_d;
            s2_prod_q <= s2_prod_d;
            s2_tag_q <= s2_tag_d;
            s2_ext_q <= s2_ext_d;
            s3_prod_q <= s3_prod_d;
            s3_tag_q <= s3_tag_d;
            s3_ext_q <= s3_ext_d;
            out_valid_q <= out_valid_d;
            out_data_q <= out_data_d;
            out_fsel_q <= out_fsel_d;
            out_paddr_q <= out_paddr_d;
            ovf_q <= ovf_d;
        end
    end

    psum_bank #(
        .NUM_FILT  (NUM_FILT),
        .PSUM_DEPTH(PSUM_DEPTH),
        .WIDTH     (ACC_WIDTH)
    ) u_bank (
        .clk  (clk),
        .rst  (rst),
        .clr  (clr),
        .we   (wr_en),
        .waddr({s3_tag_q.filt_sel, s3_tag_q.psum_addr}),
        .wdata(wr_data),
        .raddr({s3_tag_q.filt_sel, s3_tag_q.psum_addr}),
        .rdata(rd_data)
    );

    assign in_ready = advance;
    assign out_valid = out_valid_q;
    assign out_data = out_data_q;
    assign out_filt_sel = out_fsel_q;
    assign out_psum_addr = out_paddr_q;
    assign overflow = ovf_q;
    assign busy = s1_valid_q || s2_valid_q || s3_valid_q || out_valid_q;

endmodule
